// File: rtl/memory_access_pkg.sv
// =============================================================================
// memory_access_pkg -- shared ISA constants, FSM state type and store helpers
// Revision: 1.0
// =============================================================================
`default_nettype none

package memory_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size lives in funct3[1:0]; anything that is not B or H is a word.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    function automatic logic [BE_W-1:0] store_be(input logic [1:0] size,
                                                 input logic [1:0] off);
        case (size)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] store_lanes(input logic [1:0]        size,
                                                      input logic [DATA_W-1:0] data);
        case (size)
            SZ_B:    return {4{data[BYTE_W-1:0]}};
            SZ_H:    return {2{data[HALF_W-1:0]}};
            default: return data;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// =============================================================================
// load_align -- selects the addressed lane of a read word and sign/zero extends
// Revision: 1.0
// =============================================================================
`default_nettype none

module load_align
    import memory_access_pkg::*;
(
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [2:0]        i_funct3,
    input  logic [1:0]        i_off,
    output logic [DATA_W-1:0] o_data
);

    logic [BYTE_W-1:0] w_byte;
    logic [HALF_W-1:0] w_half;

    always_comb begin
        case (i_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_funct3)
            F3_B:    o_data = {{(DATA_W-BYTE_W){w_byte[BYTE_W-1]}}, w_byte};
            F3_BU:   o_data = {{(DATA_W-BYTE_W){1'b0}}, w_byte};
            F3_H:    o_data = {{(DATA_W-HALF_W){w_half[HALF_W-1]}}, w_half};
            F3_HU:   o_data = {{(DATA_W-HALF_W){1'b0}}, w_half};
            F3_W:    o_data = i_rdata;
            default: o_data = i_rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/memory_access.sv
// =============================================================================
// memory_access -- load/store stage: data-bus handshake with timeout, ALU pass-through
// Optional macro MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of truncating.
// Revision: 1.0
// =============================================================================
`default_nettype none

module memory_access
    import memory_access_pkg::*;
#(
    parameter int DMEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [2:0]        ex_funct3,
    input  logic [DATA_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_write,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [BE_W-1:0]   dmem_be,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_mem_data_select,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic [DATA_W-1:0] wb_data_result,
    output logic [4:0]        wb_rd,
    output logic              wb_reg_write,
    output logic              timeout_err
`ifdef MISALIGN_TRAP_EN
    ,
    output logic              misalign_trap
`endif
);

    localparam logic [7:0] c_LAST_WAIT = 8'(DMEM_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [7:0]        r_wait_cnt;
    logic              r_is_load;
    logic              r_we;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;
    logic [2:0]        r_funct3;
    logic [1:0]        r_off;
    logic [DATA_W-1:0] r_alu;
    logic [4:0]        r_rd;
    logic              r_reg_write;
    logic              r_wb_valid;
    logic              r_wb_sel;
    logic [DATA_W-1:0] r_wb_alu;
    logic [DATA_W-1:0] r_wb_data;
    logic [4:0]        r_wb_rd;
    logic              r_wb_rw;
    logic              r_timeout;

    logic              w_accept;
    logic              w_is_mem;
    logic              w_trap;
    logic              w_ack;
    logic              w_expire;
    logic [1:0]        w_size;
    logic [1:0]        w_off;
    logic [DATA_W-1:0] w_load_data;

    assign w_size   = ex_funct3[1:0];
    assign w_accept = (r_state == ST_IDLE) && ex_valid;
    assign w_is_mem = ex_mem_read || ex_mem_write;
    assign w_ack    = (r_state == ST_ACCESS) && dmem_ack;
    assign w_expire = (r_state == ST_ACCESS) && !dmem_ack && (r_wait_cnt == c_LAST_WAIT);

    // Lane offset truncated to the natural alignment of the access size.
    always_comb begin
        w_off = 2'b00;
        if (w_size == SZ_B) begin
            w_off = ex_addr[1:0];
        end else if (w_size == SZ_H) begin
            w_off = {ex_addr[1], 1'b0};
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic r_trap;

    assign w_trap = (w_size == SZ_H) ? ex_addr[0]
                                     : ((w_size != SZ_B) && (ex_addr[1:0] != 2'b00));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trap <= 1'b0;
        end else begin
            r_trap <= w_accept && w_is_mem && w_trap;
        end
    end

    assign misalign_trap = r_trap;
`else
    assign w_trap = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept && w_is_mem && !w_trap) w_next_state = ST_ACCESS;
            ST_ACCESS: if (w_ack || w_expire) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        ex_ready = 1'b0;
        dmem_req = 1'b0;
        case (r_state)
            ST_IDLE:   ex_ready = 1'b1;
            ST_ACCESS: dmem_req = 1'b1;
            default:   ex_ready = 1'b0;
        endcase
    end

    load_align u_load_align (
        .i_rdata  (dmem_rdata),
        .i_funct3 (r_funct3),
        .i_off    (r_off),
        .o_data   (w_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt  <= '0;
            r_is_load   <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_funct3    <= '0;
            r_off       <= '0;
            r_alu       <= '0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_sel    <= 1'b0;
            r_wb_alu    <= '0;
            r_wb_data   <= '0;
            r_wb_rd     <= '0;
            r_wb_rw     <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_timeout  <= 1'b0;
            if (w_accept) begin
                if (!w_is_mem || w_trap) begin
                    r_wb_valid <= 1'b1;
                    r_wb_alu   <= ex_alu_result;
                    r_wb_rd    <= ex_rd;
                    r_wb_rw    <= ex_reg_write && !w_is_mem;
                    r_wb_sel   <= 1'b0;
                end else begin
                    r_wait_cnt  <= '0;
                    r_is_load   <= !ex_mem_write;
                    r_we        <= ex_mem_write;
                    r_addr      <= {ex_addr[DATA_W-1:2], 2'b00};
                    r_wdata     <= store_lanes(w_size, ex_store_data);
                    r_be        <= store_be(w_size, w_off);
                    r_funct3    <= ex_funct3;
                    r_off       <= w_off;
                    r_alu       <= ex_alu_result;
                    r_rd        <= ex_rd;
                    r_reg_write <= ex_reg_write;
                end
            end
            if (r_state == ST_ACCESS) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
                if (w_ack || w_expire) begin
                    r_wb_valid <= 1'b1;
                    r_wb_alu   <= r_alu;
                    r_wb_rd    <= r_rd;
                    r_wb_rw    <= w_ack && r_is_load && r_reg_write;
                    r_wb_sel   <= w_ack && r_is_load;
                    r_timeout  <= w_expire;
                end
                if (w_ack && r_is_load) begin
                    r_wb_data <= w_load_data;
                end
            end
        end
    end

    assign dmem_we            = r_we;
    assign dmem_addr          = r_addr;
    assign dmem_wdata         = r_wdata;
    assign dmem_be            = r_be;
    assign wb_valid           = r_wb_valid;
    assign wb_mem_data_select = r_wb_sel;
    assign wb_alu_result      = r_wb_alu;
    assign wb_data_result     = r_wb_data;
    assign wb_rd              = r_wb_rd;
    assign wb_reg_write       = r_wb_rw;
    assign timeout_err        = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_memory_access.sv
// =============================================================================
// tb_memory_access -- directed cases plus randomized traffic against a
// transaction-level reference model of the memory-access stage
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_memory_access;

    localparam int TO = 16;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic        ex_mem_read = 1'b0;
    logic        ex_mem_write = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic [31:0] ex_addr = '0;
    logic [31:0] ex_store_data = '0;
    logic [31:0] ex_alu_result = '0;
    logic [4:0]  ex_rd = '0;
    logic        ex_reg_write = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid;
    logic        wb_mem_data_select;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_data_result;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        timeout_err;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    int n_vec = 0;
    int n_err = 0;

    memory_access #(.DMEM_TIMEOUT(TO)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ex_valid           (ex_valid),
        .ex_ready           (ex_ready),
        .ex_mem_read        (ex_mem_read),
        .ex_mem_write       (ex_mem_write),
        .ex_funct3          (ex_funct3),
        .ex_addr            (ex_addr),
        .ex_store_data      (ex_store_data),
        .ex_alu_result      (ex_alu_result),
        .ex_rd              (ex_rd),
        .ex_reg_write       (ex_reg_write),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_be            (dmem_be),
        .dmem_ack           (dmem_ack),
        .dmem_rdata         (dmem_rdata),
        .wb_valid           (wb_valid),
        .wb_mem_data_select (wb_mem_data_select),
        .wb_alu_result      (wb_alu_result),
        .wb_data_result     (wb_data_result),
        .wb_rd              (wb_rd),
        .wb_reg_write       (wb_reg_write),
        .timeout_err        (timeout_err)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign_trap      (misalign_trap)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] load_value(input logic [31:0] rdata, input logic [2:0] f3,
                                               input int off);
        logic [63:0] v;
        logic [63:0] mask;
        int          bits;
        bits = 8 * nbytes(f3);
        mask = (64'd1 << bits) - 64'd1;
        v    = (64'(rdata) >> (8 * off)) & mask;
        if (!f3[2] && bits < 32 && v[bits-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [31:0] lanes(input logic [31:0] sd, input int n);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % n) +: 8];
        return w;
    endfunction

    // Reference model: one outstanding bus transaction at most
    bit          m_busy = 1'b0;
    int          m_wait = 0;
    bit          m_load = 1'b0;
    logic [2:0]  m_f3 = '0;
    int          m_off = 0;
    logic [31:0] m_alu = '0;
    logic [4:0]  m_rd = '0;
    bit          m_rw = 1'b0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_alu = '0, e_data = '0;
    logic [3:0]  e_be = '0;
    logic [4:0]  e_rd = '0;
    bit          e_we = 1'b0, e_wbv = 1'b0, e_sel = 1'b0, e_rw = 1'b0, e_to = 1'b0, e_trap = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 0; m_wait = 0;
                e_addr = '0; e_wdata = '0; e_alu = '0; e_data = '0; e_be = '0; e_rd = '0;
                e_we = 0; e_wbv = 0; e_sel = 0; e_rw = 0; e_to = 0; e_trap = 0;
            end else begin
                e_wbv = 0; e_to = 0; e_trap = 0;
                if (m_busy) begin
                    m_wait++;
                    if (dmem_ack) begin
                        e_wbv = 1; e_alu = m_alu; e_rd = m_rd;
                        e_rw = m_load && m_rw; e_sel = m_load;
                        if (m_load) e_data = load_value(dmem_rdata, m_f3, m_off);
                        m_busy = 0;
                    end else if (m_wait == TO) begin
                        e_wbv = 1; e_to = 1; e_alu = m_alu; e_rd = m_rd; e_rw = 0; e_sel = 0;
                        m_busy = 0;
                    end
                end else if (ex_valid) begin
                    if (!ex_mem_read && !ex_mem_write) begin
                        e_wbv = 1; e_alu = ex_alu_result; e_rd = ex_rd; e_rw = ex_reg_write; e_sel = 0;
                    end else begin
                        int n;
                        int raw;
                        n   = nbytes(ex_funct3);
                        raw = int'(ex_addr[1:0]);
                        if (TRAP_EN && (raw % n) != 0) begin
                            e_wbv = 1; e_trap = 1; e_alu = ex_alu_result; e_rd = ex_rd; e_rw = 0; e_sel = 0;
                        end else begin
                            m_busy = 1; m_wait = 0;
                            m_load = !ex_mem_write;
                            m_off  = raw - (raw % n);
                            m_f3   = ex_funct3; m_alu = ex_alu_result; m_rd = ex_rd; m_rw = ex_reg_write;
                            e_we    = ex_mem_write;
                            e_addr  = {ex_addr[31:2], 2'b00};
                            e_be    = 4'(((1 << n) - 1) << m_off);
                            e_wdata = lanes(ex_store_data, n);
                        end
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                chk("rst_wb_valid", 32'(wb_valid), 32'd0);
                chk("rst_dmem_req", 32'(dmem_req), 32'd0);
                chk("rst_timeout", 32'(timeout_err), 32'd0);
                chk("rst_ex_ready", 32'(ex_ready), 32'd1);
                chk("rst_wb_alu", wb_alu_result, 32'd0);
            end else begin
                chk("ex_ready", 32'(ex_ready), 32'(!m_busy));
                chk("dmem_req", 32'(dmem_req), 32'(m_busy));
                if (m_busy) begin
                    chk("dmem_addr", dmem_addr, e_addr);
                    chk("dmem_we", 32'(dmem_we), 32'(e_we));
                    chk("dmem_be", 32'(dmem_be), 32'(e_be));
                    if (e_we) chk("dmem_wdata", dmem_wdata, e_wdata);
                end
                chk("wb_valid", 32'(wb_valid), 32'(e_wbv));
                chk("wb_sel", 32'(wb_mem_data_select), 32'(e_sel));
                chk("wb_alu", wb_alu_result, e_alu);
                chk("wb_data", wb_data_result, e_data);
                chk("wb_rd", 32'(wb_rd), 32'(e_rd));
                chk("wb_rw", 32'(wb_reg_write), 32'(e_rw));
                chk("timeout_err", 32'(timeout_err), 32'(e_to));
`ifdef MISALIGN_TRAP_EN
                chk("misalign_trap", 32'(misalign_trap), 32'(e_trap));
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic rd_f, input logic wr_f, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] alu, input logic [4:0] rd);
        ex_valid = 1; ex_mem_read = rd_f; ex_mem_write = wr_f; ex_funct3 = f3;
        ex_addr = addr; ex_store_data = sd; ex_alu_result = alu; ex_rd = rd; ex_reg_write = 1;
    endtask

    initial begin
        int req_cnt;
        int to_cnt;
        int wb_cnt;
        logic [31:0] seen_addr;
        logic [31:0] got_data;
        logic got_v;
        logic rw_at_to;
        logic v_at_to;
        int ack_pct;
        int kind;
        logic [2:0] f3_tab [5];
        f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // ALU pass-through
        issue(0, 0, 3'b000, 32'h0, 32'h0, 32'h1234, 5'd5);
        #1 chk("alu_ready_in", 32'(ex_ready), 32'd1);
        @(negedge clk);
        ex_valid = 0;
        chk("alu_wb_valid", 32'(wb_valid), 32'd1);
        chk("alu_wb_alu", wb_alu_result, 32'h1234);
        chk("alu_wb_rd", 32'(wb_rd), 32'd5);
        chk("alu_wb_sel", 32'(wb_mem_data_select), 32'd0);
        chk("alu_ready_out", 32'(ex_ready), 32'd1);
        @(negedge clk);
        chk("alu_wb_pulse", 32'(wb_valid), 32'd0);

        // LB with ack in the fourth request cycle
        dmem_rdata = 32'h80FF_FFFF;
        issue(1, 0, 3'b000, 32'h103, 32'h0, 32'h0, 5'd7);
        req_cnt = 0; got_v = 0; got_data = '0; seen_addr = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            ex_valid = 0;
            if (dmem_req) begin
                req_cnt++;
                seen_addr = dmem_addr;
            end
            dmem_ack = dmem_req && (req_cnt == 4);
            if (wb_valid) begin
                got_v = 1;
                got_data = wb_data_result;
            end
        end
        chk("lb_req_cycles", 32'(req_cnt), 32'd4);
        chk("lb_addr", seen_addr, 32'h100);
        chk("lb_wb_seen", 32'(got_v), 32'd1);
        chk("lb_data", got_data, 32'hFFFF_FF80);

        // SH lanes
        issue(0, 1, 3'b001, 32'h102, 32'h0000_ABCD, 32'h0, 5'd3);
        @(negedge clk);
        ex_valid = 0;
        chk("sh_be", 32'(dmem_be), 32'h0000_000C);
        chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        chk("sh_we", 32'(dmem_we), 32'd1);
        chk("sh_addr", dmem_addr, 32'h100);
        dmem_ack = 1;
        @(negedge clk);
        dmem_ack = 0;
        chk("sh_wb_valid", 32'(wb_valid), 32'd1);
        chk("sh_wb_rw", 32'(wb_reg_write), 32'd0);

        // Bus timeout
        issue(1, 0, 3'b010, 32'h200, 32'h0, 32'h0, 5'd4);
        req_cnt = 0; to_cnt = 0; rw_at_to = 1; v_at_to = 0;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            ex_valid = 0;
            dmem_ack = 0;
            if (dmem_req) req_cnt++;
            if (timeout_err) begin
                to_cnt++;
                rw_at_to = wb_reg_write;
                v_at_to = wb_valid;
            end
        end
        chk("to_req_cycles", 32'(req_cnt), 32'd16);
        chk("to_pulses", 32'(to_cnt), 32'd1);
        chk("to_wb_valid", 32'(v_at_to), 32'd1);
        chk("to_wb_rw", 32'(rw_at_to), 32'd0);
        chk("to_idle", 32'(ex_ready), 32'd1);

        // Reset in the middle of an access
        issue(1, 0, 3'b010, 32'h300, 32'h0, 32'h0, 5'd6);
        @(negedge clk);
        ex_valid = 0;
        chk("rstmid_req_before", 32'(dmem_req), 32'd1);
        rst_n = 0;
        #1 chk("rstmid_req", 32'(dmem_req), 32'd0);
        @(negedge clk);
        rst_n = 1;
        wb_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (wb_valid) wb_cnt++;
        end
        chk("rstmid_no_wb", 32'(wb_cnt), 32'd0);
        issue(0, 0, 3'b000, 32'h0, 32'h0, 32'h55AA, 5'd9);
        chk("rstmid_ready", 32'(ex_ready), 32'd1);
        @(negedge clk);
        ex_valid = 0;
        chk("rstmid_next_wb", 32'(wb_valid), 32'd1);
        chk("rstmid_next_alu", wb_alu_result, 32'h55AA);

        // Misaligned word load
        dmem_rdata = 32'hDEAD_BEEF;
        issue(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 5'd2);
        @(negedge clk);
        ex_valid = 0;
`ifdef MISALIGN_TRAP_EN
        chk("mis_no_req", 32'(dmem_req), 32'd0);
        chk("mis_trap", 32'(misalign_trap), 32'd1);
        chk("mis_wb_valid", 32'(wb_valid), 32'd1);
        chk("mis_wb_rw", 32'(wb_reg_write), 32'd0);
`else
        chk("mis_req", 32'(dmem_req), 32'd1);
        chk("mis_addr", dmem_addr, 32'h100);
        dmem_ack = 1;
        @(negedge clk);
        dmem_ack = 0;
        chk("mis_wb_valid", 32'(wb_valid), 32'd1);
        chk("mis_data", wb_data_result, 32'hDEAD_BEEF);
`endif

        // Randomized traffic, alternating busy and sluggish bus phases
        ack_pct = 3;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (cyc % 250 == 0) ack_pct = (ack_pct == 35) ? 3 : 35;
            if (cyc == 2017) begin
                rst_n = 0;
                @(negedge clk);
                rst_n = 1;
            end
            kind          = int'($urandom_range(0, 3));
            ex_valid      = 1'($urandom_range(0, 1));
            ex_mem_read   = (kind == 1) || (kind == 3);
            ex_mem_write  = (kind >= 2);
            ex_funct3     = f3_tab[$urandom_range(0, 4)];
            ex_addr       = $urandom;
            ex_store_data = $urandom;
            ex_alu_result = $urandom;
            ex_rd         = 5'($urandom);
            ex_reg_write  = 1'($urandom_range(0, 1));
            dmem_ack      = (int'($urandom_range(0, 99)) < ack_pct);
            dmem_rdata    = $urandom;
        end
        @(negedge clk);
        ex_valid = 0;
        dmem_ack = 0;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
